score_keeper: RTL and testbench
===============================

SCORE_KEEPER -- requirements
Module: score_keeper

Interface
REQ-001 SHALL have parameter SCORE_DIV, default 4: game_tick[0] pulses per score point, legal 1..16.
REQ-002 SHALL have parameter MAX_LEVEL, default 7: saturation value of speed_level, legal 1..7.
REQ-003 SHALL have ports clk (input, 1, sole clock) and rst_n (input, 1, synchronous, active-low reset); one clock, all state updates on the rising edge of clk.
REQ-004 SHALL have port game_tick (input, 2): bit 0 is the score-advance strobe, one cycle wide; bit 1 is unused.
REQ-005 SHALL have port game_state (input, 3): player state code from the player controller, with RESTART=0, JUMPING=1, RUNNING1=2, RUNNING2=3, DUCKING=4, GAME_OVER=5.
REQ-006 SHALL have port score_bcd (output, 16): current score, 4 BCD digits, with the thousands digit in [15:12].
REQ-007 SHALL have port high_score_bcd (output, 16): best score since reset, 4 BCD digits.
REQ-008 SHALL have port speed_level (output, 3): difficulty level for the obstacle generator.
REQ-009 SHALL have port milestone_pulse (output, 1): one-cycle strobe at each 100-point crossing.
REQ-010 SHALL have port new_high (output, 1): the last finished run set a new high score.

Function
REQ-011 Play states SHALL be JUMPING, RUNNING1, RUNNING2 and DUCKING; idle states SHALL be RESTART, GAME_OVER and codes 6..7.
REQ-012 SHALL register game_state into prev_state every cycle.
REQ-013 Run start SHALL be prev_state idle and game_state play.
- On run start: score, prescaler and speed_level clear to 0 and new_high clears, all visible the next cycle.
- A run start in the same cycle as game_tick[0] SHALL clear only; that tick does not count.
REQ-014 Prescaler SHALL advance on game_tick[0] only while game_state is play.
- On reaching SCORE_DIV-1 it wraps to 0 and score increments by 1, visible the cycle after that tick.
- First point of a run SHALL arrive on the SCORE_DIV-th tick.
REQ-015 Score SHALL be pure BCD; each digit rolls 9->0 with carry into the next digit.
- At 9999 score SHALL saturate; the prescaler keeps running and no pulse is generated.
REQ-016 When a score increment makes the tens and units digits 00 (score 100, 200, ...):
- milestone_pulse SHALL assert for exactly one cycle, aligned with the updated score.
- speed_level SHALL increment, saturating at MAX_LEVEL; the pulse still fires while saturated.
REQ-017 Score, prescaler and speed_level SHALL hold while game_state is idle, including across a GAME_OVER that lasts any length of time.
REQ-018 Run end SHALL be prev_state play and game_state GAME_OVER.
- If score > high_score at run end: high_score <= score and new_high <= 1, both visible the next cycle.
- Equal scores SHALL NOT update high_score or set new_high.
REQ-019 The comparison SHALL be a 16-bit magnitude compare, valid because the values are packed BCD.
REQ-020 Run end and game_tick[0] in the same cycle: no increment, since game_state is already idle.
REQ-021 A transition from play to RESTART SHALL freeze the score and SHALL NOT update high_score.

Reset
REQ-022 On rst_n=0 at a clock edge, the following SHALL reset on that edge, regardless of any run in progress:
- score_bcd, high_score_bcd, speed_level: 0
- milestone_pulse, new_high: 0
- prescaler: 0
- prev_state: RESTART

Configuration
REQ-023 Macro SCORE_HIGHSCORE_EN defined: high score register, compare and new_high SHALL be implemented as REQ-018.
REQ-024 Macro SCORE_HIGHSCORE_EN undefined:
- high_score_bcd SHALL be constant 0 and new_high SHALL be constant 0.
- No high score storage flops; all other behaviour unchanged.

Structure
REQ-025 Shared package dino_pkg SHALL hold:
- the game_state code constants and their 3-bit width;
- the score digit count (4) and BCD digit width (4).
REQ-026 Sub-module bcd_digit SHALL be instantiated 4 times in a carry chain.
- Inputs: inc, clr. Outputs: digit[3:0], carry_out (1 when the digit is 9 and inc is high).
- Saturation at 9999 SHALL be handled in score_keeper, not in bcd_digit.

Verification
REQ-027 Reset, then game_state=RUNNING1, 8 game_tick[0] pulses with SCORE_DIV=4 -> score_bcd=0x0002; the cycle after the 4th tick shows 0x0001.
REQ-028 Force score to 0x0099 in play, then 4 ticks -> score_bcd=0x0100, milestone_pulse high for 1 cycle, speed_level 0->1.
REQ-029 Score 0x0350, game_state RUNNING2->GAME_OVER with high 0 -> high_score_bcd=0x0350 and new_high=1 the next cycle; 20 further ticks in GAME_OVER leave score_bcd=0x0350.
REQ-030 High score 0x0350, game_state GAME_OVER->RUNNING1 with game_tick[0] in the same cycle -> score_bcd=0x0000, new_high=0, high_score_bcd=0x0350, prescaler 0; a run ending at 0x0350 leaves new_high=0.
REQ-031 Score 0x9999 plus 8 ticks -> score stays 0x9999 with no milestone_pulse; speed_level holds at MAX_LEVEL=7 after 0x0700.
REQ-032 Build without SCORE_HIGHSCORE_EN, run ending at 0x0123 -> high_score_bcd=0x0000 and new_high=0; REQ-027 to REQ-031 score results unchanged.

Source files
------------

// File: rtl/dino_pkg.sv
// Shared game definitions: player state codes, score digit geometry and the
// play/idle classification used by the score keeper.
package dino_pkg;

  localparam int STATE_W      = 3;
  localparam int SCORE_DIGITS = 4;
  localparam int BCD_W        = 4;

  typedef enum logic [STATE_W-1:0] {
    ST_RESTART   = 3'd0,
    ST_JUMPING   = 3'd1,
    ST_RUNNING1  = 3'd2,
    ST_RUNNING2  = 3'd3,
    ST_DUCKING   = 3'd4,
    ST_GAME_OVER = 3'd5
  } game_state_e;

  // Play covers JUMPING..DUCKING; RESTART, GAME_OVER and the spare codes are idle.
  function automatic logic is_play(input logic [STATE_W-1:0] state);
    return (state >= 3'd1) && (state <= 3'd4);
  endfunction

endpackage

// File: rtl/score_keeper_bcd_digit.sv
// One decimal digit of the score counter; digits chain through carry_out.
module bcd_digit
  import dino_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [BCD_W-1:0] digit,
  output logic             carry_out
);

  logic [BCD_W-1:0] r_digit;

  // Digit state: clear wins over increment, 9 rolls over to 0.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_digit <= 4'd0;
    end else if (clr) begin
      r_digit <= 4'd0;
    end else if (inc) begin
      r_digit <= (r_digit == 4'd9) ? 4'd0 : r_digit + 4'd1;
    end else begin
      r_digit <= r_digit;
    end
  end

  assign digit     = r_digit;
  assign carry_out = inc && (r_digit == 4'd9);

endmodule

// File: rtl/score_keeper.sv
// Score, speed level and milestone tracking for the runner game.
// Optional high-score tracking is built only when SCORE_HIGHSCORE_EN is defined.
module score_keeper
  import dino_pkg::*;
#(
  parameter int SCORE_DIV = 4,
  parameter int MAX_LEVEL = 7
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [1:0]         game_tick,
  input  logic [STATE_W-1:0] game_state,
  output logic [15:0]        score_bcd,
  output logic [15:0]        high_score_bcd,
  output logic [2:0]         speed_level,
  output logic               milestone_pulse,
  output logic               new_high
);

  localparam int PRESC_W = 4;
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(SCORE_DIV - 1);
  localparam logic [2:0]         LEVEL_MAX  = 3'(MAX_LEVEL);

  logic [STATE_W-1:0]    r_prev_state;
  logic [PRESC_W-1:0]    r_presc;
  logic [2:0]            r_level;
  logic                  r_milestone;
  logic [SCORE_DIGITS-1:0] w_digit_inc;
  logic [SCORE_DIGITS-1:0] w_carry;
  logic [15:0]           w_score;
  logic                  w_run_start;
  logic                  w_run_end;
  logic                  w_advance;
  logic                  w_inc;
  logic                  w_unused;

  assign w_run_start = !is_play(r_prev_state) && is_play(game_state);
  assign w_run_end   = is_play(r_prev_state) && (game_state == ST_GAME_OVER);
  assign w_advance   = is_play(game_state) && game_tick[0] && !w_run_start;
  // Saturation at 9999 blocks the increment here so the digits never wrap.
  assign w_inc       = w_advance && (r_presc == PRESC_LAST) && (w_score != 16'h9999);
  assign w_unused    = game_tick[1] | w_carry[SCORE_DIGITS-1];

  // Previous player state for run start/end edge detection.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_prev_state <= ST_RESTART;
    end else begin
      r_prev_state <= game_state;
    end
  end

  // Tick prescaler; keeps counting even while the score is saturated.
  always_ff @(posedge clk) begin
    if (!rst_n || w_run_start) begin
      r_presc <= 4'd0;
    end else if (w_advance) begin
      r_presc <= (r_presc == PRESC_LAST) ? 4'd0 : r_presc + 4'd1;
    end else begin
      r_presc <= r_presc;
    end
  end

  for (genvar g = 0; g < SCORE_DIGITS; g++) begin : g_digit
    if (g == 0) begin : g_lsd
      assign w_digit_inc[g] = w_inc;
    end else begin : g_upper
      assign w_digit_inc[g] = w_carry[g-1];
    end
    bcd_digit u_digit (
      .clk       (clk),
      .rst_n     (rst_n),
      .inc       (w_digit_inc[g]),
      .clr       (w_run_start),
      .digit     (w_score[g*BCD_W +: BCD_W]),
      .carry_out (w_carry[g])
    );
  end

  // A carry out of the tens digit means the low two digits just became 00.
  always_ff @(posedge clk) begin
    if (!rst_n || w_run_start) begin
      r_level     <= 3'd0;
      r_milestone <= 1'b0;
    end else begin
      r_milestone <= w_carry[1];
      if (w_carry[1] && (r_level != LEVEL_MAX)) begin
        r_level <= r_level + 3'd1;
      end else begin
        r_level <= r_level;
      end
    end
  end

`ifdef SCORE_HIGHSCORE_EN
  logic [15:0] r_high;
  logic        r_new_high;

  // Packed BCD orders like binary, so a plain magnitude compare suffices.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_high     <= 16'h0000;
      r_new_high <= 1'b0;
    end else if (w_run_start) begin
      r_high     <= r_high;
      r_new_high <= 1'b0;
    end else if (w_run_end && (w_score > r_high)) begin
      r_high     <= w_score;
      r_new_high <= 1'b1;
    end else begin
      r_high     <= r_high;
      r_new_high <= r_new_high;
    end
  end

  assign high_score_bcd = r_high;
  assign new_high       = r_new_high;
`else
  logic w_unused_hs;
  assign w_unused_hs    = w_run_end;
  assign high_score_bcd = 16'h0000;
  assign new_high       = 1'b0;
`endif

  assign score_bcd       = w_score;
  assign speed_level     = r_level;
  assign milestone_pulse = r_milestone;

endmodule

// File: tb/tb_score_keeper.sv
// Self-checking bench for score_keeper: directed vector table, corner sequences
// and randomized play against a decimal-arithmetic reference model.
module tb_score_keeper;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  game_tick;
  logic [2:0]  game_state;
  logic [15:0] score_a, high_a, score_f, high_f;
  logic [2:0]  level_a, level_f;
  logic        ms_a, nh_a, ms_f, nh_f;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef SCORE_HIGHSCORE_EN
  localparam bit HS_EN = 1'b1;
`else
  localparam bit HS_EN = 1'b0;
`endif

  always #5 clk = ~clk;

  score_keeper u_dut (
    .clk(clk), .rst_n(rst_n), .game_tick(game_tick), .game_state(game_state),
    .score_bcd(score_a), .high_score_bcd(high_a), .speed_level(level_a),
    .milestone_pulse(ms_a), .new_high(nh_a)
  );

  score_keeper #(.SCORE_DIV(1), .MAX_LEVEL(3)) u_fast (
    .clk(clk), .rst_n(rst_n), .game_tick(game_tick), .game_state(game_state),
    .score_bcd(score_f), .high_score_bcd(high_f), .speed_level(level_f),
    .milestone_pulse(ms_f), .new_high(nh_f)
  );

  typedef struct {
    int score;
    int presc;
    int level;
    int high;
    bit nh;
    bit ms;
    int prev;
  } model_t;

  typedef struct {
    bit          rstn;
    logic [2:0]  gs;
    bit          tk;
    logic [15:0] exp_score;
    bit          exp_ms;
    logic [2:0]  exp_lvl;
  } vec_t;

  model_t ma, mf;
  vec_t   vecs[$];

  function automatic model_t model_step(input model_t m, input bit rstn, input int gs,
                                        input bit tk, input int div, input int maxl);
    model_t n;
    bit play, prev_play;
    n = m;
    n.ms = 1'b0;
    play      = (gs >= 1) && (gs <= 4);
    prev_play = (m.prev >= 1) && (m.prev <= 4);
    if (!rstn) begin
      n.score = 0; n.presc = 0; n.level = 0; n.high = 0; n.nh = 1'b0;
    end else if (!prev_play && play) begin
      n.score = 0; n.presc = 0; n.level = 0; n.nh = 1'b0;
    end else if (play && tk) begin
      if (m.presc == div - 1) begin
        n.presc = 0;
        if (m.score < 9999) begin
          n.score = m.score + 1;
          if (n.score % 100 == 0) begin
            n.ms = 1'b1;
            if (n.level < maxl) n.level = m.level + 1;
          end
        end
      end else begin
        n.presc = m.presc + 1;
      end
    end else if (prev_play && gs == 5 && HS_EN && m.score > m.high) begin
      n.high = m.score;
      n.nh   = 1'b1;
    end
    n.prev = rstn ? gs : 0;
    return n;
  endfunction

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: apply inputs, advance models, compare every output of both DUTs.
  task automatic cyc(input bit rstn, input logic [2:0] gs, input bit tk);
    rst_n      = rstn;
    game_state = gs;
    game_tick  = {1'($urandom), tk};
    @(posedge clk);
    ma = model_step(ma, rstn, int'(gs), tk, 4, 7);
    mf = model_step(mf, rstn, int'(gs), tk, 1, 3);
    #1;
    chk("a.score", score_a, to_bcd(ma.score));
    chk("a.ms", 16'(ms_a), 16'(ma.ms));
    chk("a.level", 16'(level_a), 16'(ma.level));
    chk("a.high", high_a, to_bcd(ma.high));
    chk("a.new_high", 16'(nh_a), 16'(ma.nh));
    chk("f.score", score_f, to_bcd(mf.score));
    chk("f.ms", 16'(ms_f), 16'(mf.ms));
    chk("f.level", 16'(level_f), 16'(mf.level));
    chk("f.high", high_f, to_bcd(mf.high));
    chk("f.new_high", 16'(nh_f), 16'(mf.nh));
  endtask

  task automatic ticks(input int n, input logic [2:0] gs);
    for (int i = 0; i < n; i++) cyc(1'b1, gs, 1'b1);
  endtask

  initial begin
    logic [2:0] rgs;
    ma = '{default: 0};
    mf = '{default: 0};

    vecs.push_back('{1'b0, 3'd0, 1'b0, 16'h0000, 1'b0, 3'd0});
    vecs.push_back('{1'b0, 3'd2, 1'b1, 16'h0000, 1'b0, 3'd0});
    vecs.push_back('{1'b1, 3'd2, 1'b0, 16'h0000, 1'b0, 3'd0});
    vecs.push_back('{1'b1, 3'd2, 1'b1, 16'h0000, 1'b0, 3'd0});
    vecs.push_back('{1'b1, 3'd2, 1'b1, 16'h0000, 1'b0, 3'd0});
    vecs.push_back('{1'b1, 3'd2, 1'b1, 16'h0000, 1'b0, 3'd0});
    vecs.push_back('{1'b1, 3'd2, 1'b1, 16'h0001, 1'b0, 3'd0});
    vecs.push_back('{1'b1, 3'd2, 1'b1, 16'h0001, 1'b0, 3'd0});
    vecs.push_back('{1'b1, 3'd2, 1'b1, 16'h0001, 1'b0, 3'd0});
    vecs.push_back('{1'b1, 3'd2, 1'b1, 16'h0001, 1'b0, 3'd0});
    vecs.push_back('{1'b1, 3'd2, 1'b1, 16'h0002, 1'b0, 3'd0});
    vecs.push_back('{1'b1, 3'd3, 1'b0, 16'h0002, 1'b0, 3'd0});
    vecs.push_back('{1'b1, 3'd5, 1'b1, 16'h0002, 1'b0, 3'd0});
    vecs.push_back('{1'b1, 3'd5, 1'b1, 16'h0002, 1'b0, 3'd0});
    vecs.push_back('{1'b1, 3'd2, 1'b1, 16'h0000, 1'b0, 3'd0});
    vecs.push_back('{1'b1, 3'd4, 1'b1, 16'h0000, 1'b0, 3'd0});
    vecs.push_back('{1'b1, 3'd4, 1'b1, 16'h0000, 1'b0, 3'd0});
    vecs.push_back('{1'b1, 3'd4, 1'b1, 16'h0000, 1'b0, 3'd0});
    vecs.push_back('{1'b1, 3'd4, 1'b1, 16'h0001, 1'b0, 3'd0});
    vecs.push_back('{1'b1, 3'd0, 1'b1, 16'h0001, 1'b0, 3'd0});
    vecs.push_back('{1'b1, 3'd7, 1'b1, 16'h0001, 1'b0, 3'd0});
    vecs.push_back('{1'b1, 3'd1, 1'b0, 16'h0000, 1'b0, 3'd0});

    for (int i = 0; i < vecs.size(); i++) begin
      cyc(vecs[i].rstn, vecs[i].gs, vecs[i].tk);
      chk($sformatf("vec%0d.score", i), score_a, vecs[i].exp_score);
      chk($sformatf("vec%0d.ms", i), 16'(ms_a), 16'(vecs[i].exp_ms));
      chk($sformatf("vec%0d.level", i), 16'(speed_level_a()), 16'(vecs[i].exp_lvl));
    end

    // First milestone at 100 points.
    ticks(396, 3'd2);
    chk("m100.pre", score_a, 16'h0099);
    ticks(3, 3'd2);
    chk("m100.hold", score_a, 16'h0099);
    chk("m100.noms", 16'(ms_a), 16'h0000);
    ticks(1, 3'd2);
    chk("m100.score", score_a, 16'h0100);
    chk("m100.ms", 16'(ms_a), 16'h0001);
    chk("m100.level", 16'(level_a), 16'h0001);
    cyc(1'b1, 3'd2, 1'b0);
    chk("m100.ms_drop", 16'(ms_a), 16'h0000);

    // Run ends at 350, then a long GAME_OVER with ticks.
    ticks(1000, 3'd3);
    chk("r350.score", score_a, 16'h0350);
    chk("r350.level", 16'(level_a), 16'h0003);
    cyc(1'b1, 3'd5, 1'b0);
    chk("end350.high", high_a, HS_EN ? 16'h0350 : 16'h0000);
    chk("end350.nh", 16'(nh_a), 16'(HS_EN));
    ticks(20, 3'd5);
    chk("gover.score", score_a, 16'h0350);

    // Restart coinciding with a tick, then an equal-score run end.
    cyc(1'b1, 3'd2, 1'b1);
    chk("rst_tick.score", score_a, 16'h0000);
    chk("rst_tick.nh", 16'(nh_a), 16'h0000);
    chk("rst_tick.high", high_a, HS_EN ? 16'h0350 : 16'h0000);
    ticks(3, 3'd2);
    chk("presc0.hold", score_a, 16'h0000);
    ticks(1, 3'd2);
    chk("presc0.first", score_a, 16'h0001);
    ticks(1396, 3'd1);
    chk("eq350.score", score_a, 16'h0350);
    cyc(1'b1, 3'd5, 1'b0);
    chk("eq350.nh", 16'(nh_a), 16'h0000);
    chk("eq350.high", high_a, HS_EN ? 16'h0350 : 16'h0000);

    // Saturation: fast instance reaches 9999, main reaches level cap.
    cyc(1'b1, 3'd0, 1'b0);
    cyc(1'b1, 3'd2, 1'b0);
    ticks(9999, 3'd3);
    chk("sat.reach", score_f, 16'h9999);
    for (int i = 0; i < 8; i++) begin
      cyc(1'b1, 3'd3, 1'b1);
      chk("sat.noms", 16'(ms_f), 16'h0000);
    end
    chk("sat.score", score_f, 16'h9999);
    chk("sat.level_f", 16'(level_f), 16'h0003);
    chk("sat.level_a", 16'(level_a), 16'h0007);
    chk("sat.score_a", score_a, 16'h2501);

    // Randomized play with sticky states and occasional reset.
    rgs = 3'd2;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 7) == 0) rgs = 3'($urandom_range(0, 7));
      cyc(($urandom_range(0, 499) != 0), rgs, 1'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  function automatic logic [2:0] speed_level_a();
    return level_a;
  endfunction

endmodule
